// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only link between the sysid checker (master) and the system ID slave.
interface sysid_checker_if;
  logic        master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_waitrequest;

  modport master (
    output master_address,
    output master_read,
    input  master_readdata,
    input  master_waitrequest
  );

  modport slave (
    input  master_address,
    input  master_read,
    output master_readdata,
    output master_waitrequest
  );
endinterface

// File: rtl/sysid_checker.sv
// Reads system ID (word 0) and build timestamp (word 1) over Avalon-MM and
// compares them with build-time constants, flagging hardware/software mismatch.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1521130655,
  parameter logic [15:0] TIMEOUT_CYCLES     = 16'd255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  sysid_checker_if.master        bus,
  output logic [31:0]            id_value,
  output logic [31:0]            timestamp_value,
  output logic                   id_ok,
  output logic                   ts_ok,
  output logic                   pass,
  output logic                   timeout_err,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, CHECK} state_t;

  state_t      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        pending_q, pending_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        timed_out;
  logic        abort;

  // Read strobe is decoded from the state register so reset drops it at once.
  assign bus.master_read    = (state_q == RD_ID) || (state_q == RD_TS);
  assign bus.master_address = (state_q == RD_TS);

  assign timed_out = (TIMEOUT_CYCLES != 16'd0) && (wait_cnt_q == TIMEOUT_CYCLES)
                     && bus.master_waitrequest;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pending_d  = pending_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    abort      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start || pending_q) begin
          pending_d  = 1'b0;
          state_d    = RD_ID;
          wait_cnt_d = 16'd0;
          id_ok_d    = 1'b0;
          ts_ok_d    = 1'b0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          busy_d     = 1'b1;
        end
      end
      RD_ID: begin
        if (!bus.master_waitrequest) begin
          id_value_d = bus.master_readdata;
          wait_cnt_d = 16'd0;
          state_d    = RD_TS;
        end else if (timed_out) begin
          abort = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      RD_TS: begin
        if (!bus.master_waitrequest) begin
          ts_value_d = bus.master_readdata;
          wait_cnt_d = 16'd0;
          state_d    = CHECK;
        end else if (timed_out) begin
          abort = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      CHECK: begin
        id_ok_d = (id_value_q == EXPECTED_ID);
        ts_ok_d = (ts_value_q == EXPECTED_TIMESTAMP);
        pass_d  = (id_value_q == EXPECTED_ID) && (ts_value_q == EXPECTED_TIMESTAMP)
                  && !timeout_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A stalled slave ends the check without touching uncaptured values.
    if (abort) begin
      timeout_d = 1'b1;
      id_ok_d   = 1'b0;
      ts_ok_d   = 1'b0;
      pass_d    = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= 16'd0;
      pending_q  <= AUTO_START;
      id_value_q <= 32'd0;
      ts_value_q <= 32'd0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      pending_q  <= pending_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign id_value        = id_value_q;
  assign timestamp_value = ts_value_q;
  assign id_ok           = id_ok_q;
  assign ts_ok           = ts_ok_q;
  assign pass            = pass_q;
  assign timeout_err     = timeout_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench: dut_a (defaults, auto-start) on a stallable slave model,
// dut_b (TIMEOUT_CYCLES=4, no auto-start) on a permanently stalled slave.
module tb_sysid_checker;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic wr_b = 1'b1;

  logic [31:0] id_word = 32'd0;
  logic [31:0] ts_word = 32'd1521130655;
  int          stall_n = 0;
  int          stall_cnt = 0;

  int asserts = 0;
  int failures = 0;

  logic [31:0] id_value_a, ts_value_a, id_value_b, ts_value_b;
  logic id_ok_a, ts_ok_a, pass_a, tmo_a, busy_a, done_a;
  logic id_ok_b, ts_ok_b, pass_b, tmo_b, busy_b, done_b;

  sysid_checker_if bus_a();
  sysid_checker_if bus_b();

  always #5 clock = ~clock;

  sysid_checker dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .bus(bus_a),
    .id_value(id_value_a), .timestamp_value(ts_value_a),
    .id_ok(id_ok_a), .ts_ok(ts_ok_a), .pass(pass_a),
    .timeout_err(tmo_a), .busy(busy_a), .done(done_a)
  );

  sysid_checker #(.TIMEOUT_CYCLES(16'd4), .AUTO_START(1'b0)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .bus(bus_b),
    .id_value(id_value_b), .timestamp_value(ts_value_b),
    .id_ok(id_ok_b), .ts_ok(ts_ok_b), .pass(pass_b),
    .timeout_err(tmo_b), .busy(busy_b), .done(done_b)
  );

  // Slave model: each read is stalled stall_n cycles before it is accepted.
  always_comb begin
    bus_a.master_waitrequest = bus_a.master_read && (stall_cnt < stall_n);
    bus_a.master_readdata    = bus_a.master_address ? ts_word : id_word;
  end

  always @(posedge clock) begin
    if (!bus_a.master_read || !bus_a.master_waitrequest) stall_cnt <= 0;
    else stall_cnt <= stall_cnt + 1;
  end

  assign bus_b.master_waitrequest = wr_b;
  assign bus_b.master_readdata    = 32'hDEADBEEF;

  task automatic pulse_start_a();
    @(negedge clock); start_a = 1'b1;
    @(negedge clock); start_a = 1'b0;
  endtask

  task automatic wait_done_a(output int cyc);
    int n = 0;
    cyc = -1;
    while (cyc < 0 && n < 200) begin
      @(negedge clock); n++;
      if (done_a) cyc = n;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    asserts++; if (bus_a.master_read !== 1'b0) begin failures++; $display("FAIL reset_read: got %b want 0", bus_a.master_read); end
    asserts++; if ({busy_a, done_a, pass_a, id_ok_a, ts_ok_a, tmo_a} !== 6'b0) begin failures++; $display("FAIL reset_flags: got %b want 000000", {busy_a, done_a, pass_a, id_ok_a, ts_ok_a, tmo_a}); end
    asserts++; if (ts_value_a !== 32'd0) begin failures++; $display("FAIL reset_ts: got %h want 0", ts_value_a); end
    $display("reset: flags=%b read=%b", {busy_a, done_a, pass_a}, bus_a.master_read);
    reset_n = 1'b1;
  endtask

  task automatic test_auto_start();
    int rd_cnt = 0, busy_cnt = 0, done_cnt = 0, done_idx = -1;
    logic [1:0] addr_seq = 2'b11;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus_a.master_read) begin
        if (rd_cnt < 2) addr_seq[rd_cnt] = bus_a.master_address;
        rd_cnt++;
      end
      if (busy_a) busy_cnt++;
      if (done_a) begin done_cnt++; done_idx = i; end
    end
    asserts++; if (rd_cnt !== 2) begin failures++; $display("FAIL auto_read_cycles: got %0d want 2", rd_cnt); end
    asserts++; if (addr_seq !== 2'b10) begin failures++; $display("FAIL auto_addr_seq: got %b want 10", addr_seq); end
    asserts++; if (busy_cnt !== 3) begin failures++; $display("FAIL auto_busy_cycles: got %0d want 3", busy_cnt); end
    asserts++; if (done_cnt !== 1 || done_idx !== 3) begin failures++; $display("FAIL auto_done: got count %0d idx %0d want 1 idx 3", done_cnt, done_idx); end
    asserts++; if ({id_ok_a, ts_ok_a, pass_a, tmo_a} !== 4'b1110) begin failures++; $display("FAIL auto_status: got %b want 1110", {id_ok_a, ts_ok_a, pass_a, tmo_a}); end
    asserts++; if (ts_value_a !== 32'd1521130655) begin failures++; $display("FAIL auto_ts_value: got %h want %h", ts_value_a, 32'd1521130655); end
    asserts++; if (busy_b !== 1'b0) begin failures++; $display("FAIL noauto_idle: got busy %b want 0", busy_b); end
    $display("auto check: reads=%0d busy=%0d done_idx=%0d pass=%b", rd_cnt, busy_cnt, done_idx, pass_a);
  endtask

  task automatic test_ts_mismatch();
    int cyc;
    ts_word = 32'h5AAB0000;
    pulse_start_a();
    wait_done_a(cyc);
    asserts++; if (cyc !== 3) begin failures++; $display("FAIL mismatch_latency: got %0d want 3", cyc); end
    asserts++; if ({id_ok_a, ts_ok_a, pass_a} !== 3'b100) begin failures++; $display("FAIL mismatch_status: got %b want 100", {id_ok_a, ts_ok_a, pass_a}); end
    asserts++; if (ts_value_a !== 32'h5AAB0000) begin failures++; $display("FAIL mismatch_ts_value: got %h want 5aab0000", ts_value_a); end
    $display("mismatch check: ts=%h pass=%b", ts_value_a, pass_a);
    ts_word = 32'd1521130655;
  endtask

  task automatic test_stall();
    int n = 0, cyc = -1, unstable = 0, rd_cnt = 1;
    logic prev_stall = 1'b0, prev_addr = 1'b0;
    stall_n = 3;
    pulse_start_a();
    prev_stall = bus_a.master_read && bus_a.master_waitrequest;
    prev_addr  = bus_a.master_address;
    while (cyc < 0 && n < 200) begin
      @(negedge clock); n++;
      if (prev_stall && (!bus_a.master_read || bus_a.master_address !== prev_addr)) unstable++;
      if (bus_a.master_read) rd_cnt++;
      prev_stall = bus_a.master_read && bus_a.master_waitrequest;
      prev_addr  = bus_a.master_address;
      if (done_a) cyc = n;
    end
    asserts++; if (cyc !== 9) begin failures++; $display("FAIL stall_latency: got %0d want 9", cyc); end
    asserts++; if (unstable !== 0) begin failures++; $display("FAIL stall_stable: got %0d unstable cycles want 0", unstable); end
    asserts++; if (rd_cnt !== 8) begin failures++; $display("FAIL stall_read_cycles: got %0d want 8", rd_cnt); end
    asserts++; if ({pass_a, tmo_a} !== 2'b10) begin failures++; $display("FAIL stall_status: got %b want 10", {pass_a, tmo_a}); end
    $display("stall check: latency=%0d read_cycles=%0d pass=%b", cyc, rd_cnt, pass_a);
    stall_n = 0;
  endtask

  task automatic test_timeout();
    int n = 0, cyc = -1, rd_cnt = 0;
    @(negedge clock); start_b = 1'b1;
    @(negedge clock); start_b = 1'b0;
    if (bus_b.master_read) rd_cnt++;
    while (cyc < 0 && n < 200) begin
      @(negedge clock); n++;
      if (done_b) cyc = n;
      else if (bus_b.master_read) rd_cnt++;
    end
    asserts++; if (cyc !== 5) begin failures++; $display("FAIL timeout_latency: got %0d want 5", cyc); end
    asserts++; if (rd_cnt !== 5) begin failures++; $display("FAIL timeout_read_cycles: got %0d want 5", rd_cnt); end
    asserts++; if ({bus_b.master_read, busy_b, tmo_b, pass_b, id_ok_b} !== 5'b00100) begin failures++; $display("FAIL timeout_status: got %b want 00100", {bus_b.master_read, busy_b, tmo_b, pass_b, id_ok_b}); end
    asserts++; if (id_value_b !== 32'd0) begin failures++; $display("FAIL timeout_id_kept: got %h want 0", id_value_b); end
    @(negedge clock);
    asserts++; if ({done_b, tmo_b} !== 2'b01) begin failures++; $display("FAIL timeout_done_pulse: got %b want 01", {done_b, tmo_b}); end
    $display("timeout check: stalled=%0d timeout_err=%b", cyc, tmo_b);
  endtask

  task automatic test_back_to_back();
    int cyc, extra_busy = 0;
    @(negedge clock); start_a = 1'b1;
    repeat (3) @(negedge clock);
    start_a = 1'b0;
    @(negedge clock);
    asserts++; if ({done_a, pass_a} !== 2'b11) begin failures++; $display("FAIL b2b_first_done: got %b want 11", {done_a, pass_a}); end
    start_a = 1'b1;
    @(negedge clock); start_a = 1'b0;
    asserts++; if ({done_a, busy_a, id_ok_a, pass_a} !== 4'b0100) begin failures++; $display("FAIL b2b_accept: got %b want 0100", {done_a, busy_a, id_ok_a, pass_a}); end
    wait_done_a(cyc);
    asserts++; if (cyc !== 3 || pass_a !== 1'b1) begin failures++; $display("FAIL b2b_second: got latency %0d pass %b want 3 1", cyc, pass_a); end
    repeat (6) begin
      @(negedge clock);
      if (busy_a) extra_busy++;
    end
    asserts++; if (extra_busy !== 0) begin failures++; $display("FAIL b2b_no_queue: got %0d busy cycles want 0", extra_busy); end
    $display("back-to-back: second latency=%0d extra_busy=%0d", cyc, extra_busy);
  endtask

  task automatic test_reset_mid();
    int cyc;
    pulse_start_a();
    @(negedge clock);
    asserts++; if ({bus_a.master_read, bus_a.master_address} !== 2'b11) begin failures++; $display("FAIL midreset_in_rdts: got %b want 11", {bus_a.master_read, bus_a.master_address}); end
    #2 reset_n = 1'b0;
    #1;
    asserts++; if ({bus_a.master_read, busy_a, pass_a, id_ok_a} !== 4'b0) begin failures++; $display("FAIL midreset_async: got %b want 0000", {bus_a.master_read, busy_a, pass_a, id_ok_a}); end
    asserts++; if (ts_value_a !== 32'd0) begin failures++; $display("FAIL midreset_ts_clear: got %h want 0", ts_value_a); end
    repeat (2) @(negedge clock);
    asserts++; if (done_a !== 1'b0) begin failures++; $display("FAIL midreset_no_done: got %b want 0", done_a); end
    reset_n = 1'b1;
    wait_done_a(cyc);
    asserts++; if (cyc !== 4 || pass_a !== 1'b1) begin failures++; $display("FAIL midreset_rerun: got latency %0d pass %b want 4 1", cyc, pass_a); end
    asserts++; if (ts_value_a !== 32'd1521130655) begin failures++; $display("FAIL midreset_ts_value: got %h want %h", ts_value_a, 32'd1521130655); end
    $display("mid-check reset: rerun latency=%0d pass=%b", cyc, pass_a);
  endtask

  initial begin
    test_reset();
    test_auto_start();
    test_ts_mismatch();
    test_stall();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule
